// File: rtl/block_readout_sched_pkg.sv
// Shared types for the block readout bus: block count, block index type and scheduler states.
package block_readout_pkg;

    localparam int NUM_BLOCKS = 12;
    localparam int BLK_W      = 4;

    typedef logic [BLK_W-1:0] blk_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        HOLD
    } state_t;

    // One-hot request vector for a 1-based block index; out-of-range index gives all zero.
    function automatic logic [NUM_BLOCKS:1] blk_onehot(input blk_idx_t idx);
        logic [NUM_BLOCKS:1] v;
        v = '0;
        for (int b = 1; b <= NUM_BLOCKS; b++) begin
            if (idx == BLK_W'(b)) begin
                v[b] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/block_readout_sched_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping N -> 1.
// Shared by the bus masters that arbitrate over 1-based block request vectors.
module rr_pick
    import block_readout_pkg::*;
#(
    parameter int N     = NUM_BLOCKS,
    parameter int IDX_W = BLK_W
) (
    input  logic [N:1]       req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr_i) + k - 1) % N + 1);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        hit_o = found;
    end

endmodule

// File: rtl/block_readout_sched.sv
// Round-robin readout scheduler for the block result FIFOs on the shared serial bus.
// Optional BLOCK_READOUT_PARITY_EN: each word carries a trailing even-parity bit, checked into out_perr.
module block_readout_sched
    import block_readout_pkg::*;
#(
    parameter int WORD_BITS = 32,
    parameter int READ_LAT  = 2
) (
    input  logic                 fifo_clk,
    input  logic                 fifo_rst,
    input  logic [NUM_BLOCKS:1]  fifo_empty,
    output logic [NUM_BLOCKS:1]  fifo_req,
    input  logic                 fifo_bit,
    output logic [WORD_BITS-1:0] out_word,
    output logic [BLK_W-1:0]     out_src,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef BLOCK_READOUT_PARITY_EN
    output logic                 out_perr,
`endif
    output logic                 busy
);

`ifdef BLOCK_READOUT_PARITY_EN
    localparam int NBITS = WORD_BITS + 1;
`else
    localparam int NBITS = WORD_BITS;
`endif
    localparam int CNT_W = $clog2(WORD_BITS + READ_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(WORD_BITS);

    state_t                state_q;
    blk_idx_t              ptr_q;
    blk_idx_t              sel_q;
    logic [NUM_BLOCKS:1]   req_q;
    logic [CNT_W-1:0]      req_cnt_q;
    logic [CNT_W-1:0]      cap_cnt_q, cap_cnt_d;
    logic [READ_LAT-1:0]   cap_vld_q, cap_vld_d;
    logic [WORD_BITS-1:0]  word_q, word_d;
    logic                  valid_q;
    logic                  cap_fire;
    logic                  cap_last;
    logic                  pick_hit;
    blk_idx_t              pick_idx;
`ifdef BLOCK_READOUT_PARITY_EN
    logic                  par_q, par_d;
    logic                  perr_q;
`endif

    rr_pick #(
        .N     (NUM_BLOCKS),
        .IDX_W (BLK_W)
    ) u_pick (
        .req_i (~fifo_empty),
        .ptr_i (ptr_q),
        .hit_o (pick_hit),
        .idx_o (pick_idx)
    );

    // Capture side: a delayed copy of "req was high" marks which cycles carry a bus bit.
    always_comb begin
        cap_vld_d    = cap_vld_q << 1;
        cap_vld_d[0] = |req_q;
        cap_fire     = cap_vld_q[READ_LAT-1];
        cap_last     = cap_fire && (cap_cnt_q == LAST_BIT);
        cap_cnt_d    = cap_cnt_q;
        word_d       = word_q;
`ifdef BLOCK_READOUT_PARITY_EN
        par_d        = par_q;
`endif
        if (cap_fire) begin
            cap_cnt_d = cap_last ? '0 : cap_cnt_q + CNT_W'(1);
            if (cap_cnt_q < DATA_BITS) begin
                word_d = {word_q[WORD_BITS-2:0], fifo_bit};
            end
`ifdef BLOCK_READOUT_PARITY_EN
            par_d = cap_last ? 1'b0 : (par_q ^ fifo_bit);
`endif
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (fifo_rst) begin
            state_q   <= IDLE;
            ptr_q     <= BLK_W'(NUM_BLOCKS);
            sel_q     <= '0;
            req_q     <= '0;
            req_cnt_q <= '0;
            cap_cnt_q <= '0;
            cap_vld_q <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
`ifdef BLOCK_READOUT_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            cap_vld_q <= cap_vld_d;
            cap_cnt_q <= cap_cnt_d;
            word_q    <= word_d;
`ifdef BLOCK_READOUT_PARITY_EN
            par_q     <= par_d;
            if (cap_last) begin
                perr_q <= par_q ^ fifo_bit;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (pick_hit) begin
                        sel_q     <= pick_idx;
                        ptr_q     <= pick_idx;
                        req_q     <= blk_onehot(pick_idx);
                        req_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (req_cnt_q == LAST_BIT) begin
                        req_q     <= '0;
                        req_cnt_q <= '0;
                        state_q   <= DRAIN;
                    end else begin
                        req_cnt_q <= req_cnt_q + CNT_W'(1);
                    end
                end
                // Requests are done; wait for the bus latency to deliver the tail bits.
                DRAIN: begin
                    if (cap_last) begin
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_req  = req_q;
    assign out_word  = word_q;
    assign out_src   = sel_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
`ifdef BLOCK_READOUT_PARITY_EN
    assign out_perr  = perr_q;
`endif

endmodule
